// File: rtl/fir_tap_sequencer.sv
// FIR lane tap sequencer: keeps a circular delay line of input samples in a
// dual-port BRAM and streams the NumTaps newest samples, newest first, with
// their coefficient index to the MAC. The delay line is zero-filled after
// reset and whenever clear_i is seen in IDLE.
module fir_tap_sequencer #(
    parameter int AddrWidth = 10,
    parameter int DataSize  = 16,
    parameter int NumTaps   = 64,
    localparam int CoeffW   = (NumTaps > 1) ? $clog2(NumTaps) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic [DataSize-1:0]  sample_i,
    output logic                 bram_wvalid_o,
    output logic [AddrWidth-1:0] bram_waddr_o,
    output logic [DataSize-1:0]  bram_wdata_o,
    output logic [AddrWidth-1:0] bram_raddr_o,
    input  logic [DataSize-1:0]  bram_rdata_i,
    output logic                 tap_valid_o,
    output logic [DataSize-1:0]  tap_data_o,
    output logic [CoeffW-1:0]    coeff_addr_o,
    output logic                 tap_first_o,
    output logic                 tap_last_o,
    output logic                 busy_o
);

    // Tap counter must be able to hold NumTaps itself (the "all reads issued" value).
    localparam int KW = $clog2(NumTaps + 1);

    if (NumTaps < 1 || NumTaps > 2**AddrWidth) begin : g_bad_num_taps
        $error("fir_tap_sequencer: NumTaps must be in 1 .. 2**AddrWidth");
    end

    // CLEAR is the all-zero encoding so reset lands there directly.
    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   wptr_q, wptr_d;
    // Extra MSB marks the end of the zero-fill sweep.
    logic [AddrWidth:0]     clr_cnt_q, clr_cnt_d;
    // Index of the next read to issue while in READ.
    logic [KW-1:0]          kcnt_q, kcnt_d;

    logic                   wvalid_q, wvalid_d;
    logic [AddrWidth-1:0]   waddr_q, waddr_d;
    logic [DataSize-1:0]    wdata_q, wdata_d;

    // Read-issue stage: the address and the tap it belongs to.
    logic [AddrWidth-1:0]   raddr_q, raddr_d;
    logic                   rvld_q, rvld_d;
    logic [CoeffW-1:0]      rk_q, rk_d;

    // Tap stage: read-issue signals delayed one cycle to line up with rdata.
    logic                   tap_valid_q, tap_valid_d;
    logic [CoeffW-1:0]      coeff_q, coeff_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        clr_cnt_d   = clr_cnt_q;
        kcnt_d      = kcnt_q;
        wvalid_d    = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        rvld_d      = 1'b0;
        rk_d        = rk_q;

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q[AddrWidth]) begin
                    // Sweep finished: the last zero write is already on the port.
                    state_d = ST_IDLE;
                    wptr_d  = '0;
                end else begin
                    wvalid_d  = 1'b1;
                    waddr_d   = clr_cnt_q[AddrWidth-1:0];
                    wdata_d   = '0;
                    clr_cnt_d = clr_cnt_q + (AddrWidth+1)'(1);
                end
            end
            ST_IDLE: begin
                if (clear_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (sample_valid_i) begin
                    // Accepted sample is held in the write-data register.
                    state_d  = ST_WRITE;
                    wvalid_d = 1'b1;
                    waddr_d  = wptr_q;
                    wdata_d  = sample_i;
                end
            end
            ST_WRITE: begin
                // Issue tap 0 (the sample being written this cycle).
                state_d = ST_READ;
                raddr_d = wptr_q;
                rvld_d  = 1'b1;
                rk_d    = '0;
                kcnt_d  = KW'(1);
            end
            ST_READ: begin
                if (kcnt_q == KW'(NumTaps)) begin
                    state_d = ST_DRAIN;
                end else begin
                    raddr_d = wptr_q - AddrWidth'(kcnt_q);
                    rvld_d  = 1'b1;
                    rk_d    = CoeffW'(kcnt_q);
                    kcnt_d  = kcnt_q + KW'(1);
                end
            end
            ST_DRAIN: begin
                wptr_d  = wptr_q + AddrWidth'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        tap_valid_d = rvld_q;
        coeff_d     = rk_q;
        first_d     = rvld_q && (rk_q == '0);
        last_d      = rvld_q && (rk_q == CoeffW'(NumTaps - 1));
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_CLEAR;
            wptr_q      <= '0;
            clr_cnt_q   <= '0;
            kcnt_q      <= '0;
            wvalid_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rvld_q      <= 1'b0;
            rk_q        <= '0;
            tap_valid_q <= 1'b0;
            coeff_q     <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            clr_cnt_q   <= clr_cnt_d;
            kcnt_q      <= kcnt_d;
            wvalid_q    <= wvalid_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            rvld_q      <= rvld_d;
            rk_q        <= rk_d;
            tap_valid_q <= tap_valid_d;
            coeff_q     <= coeff_d;
            first_q     <= first_d;
            last_q      <= last_d;
        end
    end

    assign sample_ready_o = (state_q == ST_IDLE);
    assign busy_o         = (state_q != ST_IDLE);
    assign bram_wvalid_o  = wvalid_q;
    assign bram_waddr_o   = waddr_q;
    assign bram_wdata_o   = wdata_q;
    assign bram_raddr_o   = raddr_q;
    assign tap_valid_o    = tap_valid_q;
    assign tap_data_o     = bram_rdata_i;
    assign coeff_addr_o   = coeff_q;
    assign tap_first_o    = first_q;
    assign tap_last_o     = last_q;

endmodule
